// File: rtl/matrix_frame_scroller_pkg.sv
// Shared types and constants for the LED matrix frame scroller.
// Build option: MATRIX_INVERT_EN inverts displayed rows for active-high boards.
package matrix_pkg;

    localparam int ROWS  = 8;
    localparam int ROW_W = 8;

    typedef logic [ROW_W-1:0]         row_t;
    typedef logic [$clog2(ROWS)-1:0]  row_idx_t;

    // A stored 1 is an unlit LED, so an all-ones row is blank.
    localparam row_t BLANK_ROW = 8'hFF;

    typedef enum logic {
        SCROLL_UP   = 1'b0,   // offset + 1 per tick
        SCROLL_DOWN = 1'b1    // offset - 1 per tick
    } scroll_dir_e;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1     // commit seen, waiting for a scroll boundary
    } commit_state_e;

    // Maps a stored (active-low) row to the polarity presented to the scanner.
    function automatic row_t display_row(input row_t stored);
`ifdef MATRIX_INVERT_EN
        return ~stored;
`else
        return stored;
`endif
    endfunction

endpackage

// File: rtl/matrix_frame_scroller_if.sv
// Host-side write/commit bus into the shadow pattern bank.
interface matrix_frame_scroller_if #(
    parameter int ADDR_W = 4
) ();
    import matrix_pkg::*;

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    row_t              wr_data;
    logic              commit;

    modport master (output wr_valid, output wr_addr, output wr_data, output commit,
                    input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data, input  commit,
                    output wr_ready);
endinterface

// File: rtl/matrix_frame_scroller_tick_gen.sv
// Free-running prescaler producing a 1-cycle scroll tick every TICK_DIV clocks.
module matrix_tick_gen #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CNT_W = $clog2(TICK_DIV);

    logic [CNT_W-1:0] count_reg;

    assign tick = (count_reg == CNT_W'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap; runs whether or not scrolling is enabled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end
endmodule

// File: rtl/matrix_frame_scroller.sv
// Double-buffered 8x8 LED pattern store with scroll window and tear-free commit.
// Build option: MATRIX_INVERT_EN presents inverted rows (reset rd_data 8'h00).
module matrix_frame_scroller
    import matrix_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int TICK_DIV = 12500000
) (
    input  logic                     clk,
    input  logic                     reset,
    matrix_frame_scroller_if.slave   wr_bus,
    input  logic                     scroll_en,
    input  logic                     scroll_dir,
    input  row_idx_t                 rd_row,
    output row_t                     rd_data,
    output logic [$clog2(DEPTH)-1:0] offset,
    output logic                     swap_done
);
    localparam int ADDR_W = $clog2(DEPTH);

    commit_state_e     state_reg, state_next;
    logic              active_reg;           // index of the bank being displayed
    logic [ADDR_W-1:0] offset_reg, offset_next;
    logic              swap_done_reg;
    row_t              rd_data_reg;

    logic              tick;
    logic              swap;
    logic              wr_fire;
    logic [1:0]        bank_wr_en;
    logic [ADDR_W-1:0] rd_idx;
    row_t [1:0]        bank_row;

    matrix_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Writes are refused while a commit waits, so the pending frame stays frozen.
    assign wr_bus.wr_ready = (state_reg == ST_IDLE);
    assign wr_fire         = wr_bus.wr_valid && wr_bus.wr_ready;
    assign bank_wr_en[0]   = wr_fire &&  active_reg;
    assign bank_wr_en[1]   = wr_fire && !active_reg;

    // Window index wraps naturally in ADDR_W bits.
    assign rd_idx = offset_reg + ADDR_W'(rd_row);

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        row_t mem_reg [DEPTH];

        // Pattern bank: blank on reset, written only while it is the shadow.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem_reg[i] <= BLANK_ROW;
                end
            end else if (bank_wr_en[gi]) begin
                mem_reg[wr_bus.wr_addr] <= wr_bus.wr_data;
            end
        end

        assign bank_row[gi] = mem_reg[rd_idx];
    end

    // Commit sequencing: a stopped display swaps at once, a scrolling one on a tick.
    always_comb begin
        state_next = state_reg;
        swap       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wr_bus.commit) begin
                    state_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (tick || !scroll_en) begin
                    swap       = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Scroll offset: a swap restarts the window at 0 and overrides any step.
    always_comb begin
        offset_next = offset_reg;
        if (swap) begin
            offset_next = '0;
        end else if (tick && scroll_en) begin
            if (scroll_dir_e'(scroll_dir) == SCROLL_DOWN) begin
                offset_next = offset_reg - ADDR_W'(1);
            end else begin
                offset_next = offset_reg + ADDR_W'(1);
            end
        end
    end

    // Control state, bank select and the registered read port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= ST_IDLE;
            active_reg    <= 1'b0;
            offset_reg    <= '0;
            swap_done_reg <= 1'b0;
            rd_data_reg   <= display_row(BLANK_ROW);
        end else begin
            state_reg     <= state_next;
            active_reg    <= active_reg ^ swap;
            offset_reg    <= offset_next;
            swap_done_reg <= swap;
            rd_data_reg   <= display_row(bank_row[active_reg]);
        end
    end

    assign rd_data   = rd_data_reg;
    assign offset    = offset_reg;
    assign swap_done = swap_done_reg;
endmodule
